// File: rtl/thresh_pkg.sv
// Shared constants and types for the threshold scheduler slice.
package thresh_pkg;

    localparam int         PIX_W  = 8;
    localparam int         CNT_W  = 20;
    localparam logic [7:0] DEF_LO = 8'h90;
    localparam logic [7:0] DEF_HI = 8'hF0;
    localparam int         STEP   = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_EVAL   = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [PIX_W-1:0] lo;
        logic [PIX_W-1:0] hi;
    } thresh_cfg_t;

endpackage

// File: rtl/threshold_sched_if.sv
// Host config, camera timing, mask feedback and threshold outputs of the scheduler.
interface threshold_sched_if #(
    parameter int PIX_W = thresh_pkg::PIX_W,
    parameter int CNT_W = thresh_pkg::CNT_W
);
    logic             cfg_valid_in;
    logic [PIX_W-1:0] cfg_lo_in;
    logic [PIX_W-1:0] cfg_hi_in;
    logic             cfg_ready_out;
    logic             auto_en_in;
    logic [CNT_W-1:0] target_cnt_in;
    logic             frame_start_in;
    logic             frame_end_in;
    logic             mask_valid_in;
    logic             mask_in;
    logic [PIX_W-1:0] lo_out;
    logic [PIX_W-1:0] hi_out;
    logic [CNT_W-1:0] hit_cnt_out;
    logic             hit_valid_out;

    // Driver side: host, camera timing and mask stage feedback.
    modport master (
        output cfg_valid_in, cfg_lo_in, cfg_hi_in, auto_en_in, target_cnt_in,
        output frame_start_in, frame_end_in, mask_valid_in, mask_in,
        input  cfg_ready_out, lo_out, hi_out, hit_cnt_out, hit_valid_out
    );

    // Scheduler side.
    modport slave (
        input  cfg_valid_in, cfg_lo_in, cfg_hi_in, auto_en_in, target_cnt_in,
        input  frame_start_in, frame_end_in, mask_valid_in, mask_in,
        output cfg_ready_out, lo_out, hi_out, hit_cnt_out, hit_valid_out
    );
endinterface

// File: rtl/threshold_sched_hit_counter.sv
// Saturating per-frame hit counter; a clear cycle also counts its own hit.
module hit_counter #(
    parameter int CNT_W = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart on clear, otherwise step up and hold at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            if (inc_i) begin
                cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = '0;
            end
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/threshold_sched.sv
// Frame-synchronous owner of the mask lo/hi thresholds: host updates and auto
// adjustment are applied only in the single EVAL cycle after frame_end.
module threshold_sched #(
    parameter int               PIX_W  = thresh_pkg::PIX_W,
    parameter int               CNT_W  = thresh_pkg::CNT_W,
    parameter logic [PIX_W-1:0] DEF_LO = thresh_pkg::DEF_LO,
    parameter logic [PIX_W-1:0] DEF_HI = thresh_pkg::DEF_HI,
    parameter int               STEP   = thresh_pkg::STEP
) (
    input  logic             clk_in,
    input  logic             rst_in,
    threshold_sched_if.slave bus
);
    import thresh_pkg::*;

    localparam logic [1:0]     ST_IDLE   = S_IDLE;
    localparam logic [1:0]     ST_ACTIVE = S_ACTIVE;
    localparam logic [1:0]     ST_EVAL   = S_EVAL;
    localparam logic [PIX_W:0] STEP_X    = (PIX_W+1)'(STEP);
    localparam logic [PIX_W:0] ONE_X     = {{PIX_W{1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [PIX_W-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [PIX_W-1:0] sh_lo_q, sh_lo_d, sh_hi_q, sh_hi_d;
    logic             pend_q, pend_d;
    logic             hval_q, hval_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;

    logic [CNT_W-1:0] cnt_s;
    logic             hit_s, cnt_inc_s, cap_s;
    logic [CNT_W-1:0] band_s;
    logic [CNT_W:0]   upper_s;
    logic             over_s, under_s, at_top_s;
    logic [PIX_W:0]   lo_x_s, hi_x_s, lo_up_s, hi_m1_s, lo_inc_x_s, lo_dec_x_s;

    assign hit_s     = bus.mask_valid_in && bus.mask_in;
    // frame_start counts in any state so the first pixel of a frame is never lost.
    assign cnt_inc_s = hit_s && ((state_q == ST_ACTIVE) || bus.frame_start_in);
    assign cap_s     = bus.cfg_valid_in && !pend_q;

    hit_counter #(.CNT_W(CNT_W)) u_hit_counter (
        .clk_i (clk_in),
        .rst_i (rst_in),
        .clr_i (bus.frame_start_in),
        .inc_i (cnt_inc_s),
        .cnt_o (cnt_s)
    );

    // Auto-mode: compare hits to target +/- target/8 and form candidate lo values.
    always_comb begin
        band_s  = bus.target_cnt_in >> 3'd3;
        upper_s = {1'b0, bus.target_cnt_in} + {1'b0, band_s};
        over_s  = ({1'b0, cnt_s} > upper_s);
        if (bus.target_cnt_in > band_s) begin
            under_s = (cnt_s < (bus.target_cnt_in - band_s));
        end else begin
            under_s = 1'b0;
        end
        lo_x_s   = {1'b0, lo_q};
        hi_x_s   = {1'b0, hi_q};
        lo_up_s  = lo_x_s + STEP_X;
        hi_m1_s  = hi_x_s - ONE_X;
        // One extra bit keeps lo+1 and hi-1 from wrapping near the range ends.
        at_top_s = ((lo_x_s + ONE_X) >= hi_x_s);
        if (at_top_s) begin
            lo_inc_x_s = lo_x_s;
        end else if (lo_up_s < hi_m1_s) begin
            lo_inc_x_s = lo_up_s;
        end else begin
            lo_inc_x_s = hi_m1_s;
        end
        if (lo_x_s >= STEP_X) begin
            lo_dec_x_s = lo_x_s - STEP_X;
        end else begin
            lo_dec_x_s = '0;
        end
    end

    // Frame FSM; frame_start during EVAL goes straight back to ACTIVE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.frame_start_in) begin
                    state_d = bus.frame_end_in ? ST_EVAL : ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (bus.frame_end_in) begin
                    state_d = ST_EVAL;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_EVAL: begin
                if (bus.frame_start_in) begin
                    state_d = bus.frame_end_in ? ST_EVAL : ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Threshold, shadow config and hit report updates.
    always_comb begin
        lo_d    = lo_q;
        hi_d    = hi_q;
        sh_lo_d = sh_lo_q;
        sh_hi_d = sh_hi_q;
        pend_d  = pend_q;
        hcnt_d  = hcnt_q;
        hval_d  = 1'b0;
        if (state_q == ST_EVAL) begin
            hcnt_d = cnt_s;
            hval_d = 1'b1;
            if (pend_q) begin
                // A host update wins over auto adjustment for this frame.
                lo_d   = sh_lo_q;
                hi_d   = sh_hi_q;
                pend_d = 1'b0;
            end else if (bus.auto_en_in) begin
                if (over_s) begin
                    lo_d = PIX_W'(lo_inc_x_s);
                end else if (under_s) begin
                    lo_d = PIX_W'(lo_dec_x_s);
                end else begin
                    lo_d = lo_q;
                end
            end else begin
                lo_d = lo_q;
            end
        end else begin
            hval_d = 1'b0;
        end
        // Capture stores the ordered pair so the mask window is never inverted.
        if (cap_s) begin
            pend_d = 1'b1;
            if (bus.cfg_lo_in > bus.cfg_hi_in) begin
                sh_lo_d = bus.cfg_hi_in;
                sh_hi_d = bus.cfg_lo_in;
            end else begin
                sh_lo_d = bus.cfg_lo_in;
                sh_hi_d = bus.cfg_hi_in;
            end
        end else begin
            sh_lo_d = sh_lo_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            lo_q    <= DEF_LO;
            hi_q    <= DEF_HI;
            sh_lo_q <= DEF_LO;
            sh_hi_q <= DEF_HI;
            pend_q  <= 1'b0;
            hval_q  <= 1'b0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            sh_lo_q <= sh_lo_d;
            sh_hi_q <= sh_hi_d;
            pend_q  <= pend_d;
            hval_q  <= hval_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign bus.cfg_ready_out = !pend_q;
    assign bus.lo_out        = lo_q;
    assign bus.hi_out        = hi_q;
    assign bus.hit_cnt_out   = hcnt_q;
    assign bus.hit_valid_out = hval_q;

endmodule
